// File: rtl/stack_pkg.sv
// stack_pkg: shared types and default sizes for the LIFO stack controller.
// Kept separate so the RAM and board top agree on widths.
`timescale 1ns/1ps
package stack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH_LOG2 = 8;

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences push/pop pulses onto an external sync-read RAM,
// owns the stack pointer, returns popped data with a one-cycle strobe.
`timescale 1ns/1ps
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_W-1:0]     din,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT =
        {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = (DEPTH_LOG2)'(1);

    state_t state;
    logic   take_push;
    logic   take_pop;

    // Status flags decode straight from the occupancy counter and state.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // Push has priority; a pop only proceeds when no push is accepted.
    assign take_push = push && !full;
    assign take_pop  = pop && !empty && !take_push;

    // Request sequencer: one write cycle per push, RD+CAP per pop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            count      <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            unique case (state)
                IDLE: begin
                    err <= (push && !take_push) || (pop && !take_pop);
                    if (take_push) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= count[DEPTH_LOG2-1:0];
                        ram_wdata <= din;
                        count     <= count + CNT_ONE;
                        state     <= WR;
                    end else if (take_pop) begin
                        ram_addr <= count[DEPTH_LOG2-1:0] - ADDR_ONE;
                        count    <= count - CNT_ONE;
                        state    <= RD;
                    end
                end
                WR: begin
                    err   <= push || pop;
                    state <= IDLE;
                end
                RD: begin
                    err   <= push || pop;
                    state <= CAP;
                end
                CAP: begin
                    err        <= push || pop;
                    dout       <= ram_rdata;
                    dout_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: vector table, directed corner cases and random traffic
// against a queue-based LIFO reference model.
`timescale 1ns/1ps
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       push, pop;
    logic [7:0] din;
    logic       ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic [7:0] dout;
    logic       dout_valid;
    logic [8:0] count;
    logic       full, empty, busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    stack_ctrl #(.DATA_W(8), .DEPTH_LOG2(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read RAM, one cycle latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp_v, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    int         m_busy;
    bit         m_pend;
    logic [7:0] m_val;
    logic [7:0] m_dout;

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_pend = 0;
        m_val  = 8'h00;
        m_dout = 8'h00;
    endtask

    // Drive one cycle of requests, advance, compare against the model.
    task automatic step(input bit pu, input bit po, input logic [7:0] d);
        bit m_err, m_dv, m_we, m_adr_chk;
        int m_addr;
        logic [7:0] m_wd;
        m_err = 0; m_dv = 0; m_we = 0; m_adr_chk = 0;
        m_addr = 0; m_wd = 8'h00;
        push = pu; pop = po; din = d;
        if (m_busy > 0) begin
            m_err = pu | po;
            m_busy--;
            if (m_busy == 0 && m_pend) begin
                m_dv   = 1;
                m_dout = m_val;
                m_pend = 0;
            end
        end else if (pu && q.size() < 256) begin
            m_we = 1; m_adr_chk = 1;
            m_addr = q.size(); m_wd = d;
            q.push_back(d);
            m_busy = 1;
            m_err  = po;
        end else if (po && q.size() > 0) begin
            m_adr_chk = 1;
            m_addr = q.size() - 1;
            m_val  = q.pop_back();
            m_pend = 1;
            m_busy = 2;
            m_err  = pu;
        end else begin
            m_err = pu | po;
        end
        @(posedge clk); #1;
        push = 0; pop = 0;
        chk("count", int'(count), q.size());
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("full", int'(full), int'(q.size() == 256));
        chk("busy", int'(busy), int'(m_busy > 0));
        chk("err", int'(err), int'(m_err));
        chk("dout_valid", int'(dout_valid), int'(m_dv));
        chk("dout", int'(dout), int'(m_dout));
        chk("ram_we", int'(ram_we), int'(m_we));
        if (m_adr_chk) chk("ram_addr", int'(ram_addr), m_addr);
        if (m_we) chk("ram_wdata", int'(ram_wdata), int'(m_wd));
    endtask

    // Asynchronous clear mid-cycle; outputs must drop before any edge.
    task automatic do_clr();
        clr = 1;
        #1;
        chk("clr_ram_we", int'(ram_we), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_busy", int'(busy), 0);
        chk("clr_dout", int'(dout), 0);
        chk("clr_dv", int'(dout_valid), 0);
        model_reset();
        #2;
        clr = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         pu, po;
        logic [7:0] d;
        int         cnt;
        bit         er, dv;
        logic [7:0] dq;
        bit         we;
        logic [7:0] ad;
        bit         bz;
    } vec_t;

    vec_t tbl[22];

    initial begin
        clr = 1; push = 0; pop = 0; din = 8'h00;
        model_reset();
        //          pu po d     cnt er dv dout  we addr  bz
        tbl[0]  = '{1, 0, 8'h12, 1, 0, 0, 8'h00, 1, 8'd0, 1};
        tbl[1]  = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'd0, 0};
        tbl[2]  = '{1, 0, 8'h34, 2, 0, 0, 8'h00, 1, 8'd1, 1};
        tbl[3]  = '{0, 0, 8'h00, 2, 0, 0, 8'h00, 0, 8'd1, 0};
        tbl[4]  = '{1, 0, 8'h56, 3, 0, 0, 8'h00, 1, 8'd2, 1};
        tbl[5]  = '{0, 0, 8'h00, 3, 0, 0, 8'h00, 0, 8'd2, 0};
        tbl[6]  = '{0, 1, 8'h00, 2, 0, 0, 8'h00, 0, 8'd2, 1};
        tbl[7]  = '{0, 0, 8'h00, 2, 0, 0, 8'h00, 0, 8'd2, 1};
        tbl[8]  = '{0, 0, 8'h00, 2, 0, 1, 8'h56, 0, 8'd2, 0};
        tbl[9]  = '{0, 1, 8'h00, 1, 0, 0, 8'h56, 0, 8'd1, 1};
        tbl[10] = '{0, 0, 8'h00, 1, 0, 0, 8'h56, 0, 8'd1, 1};
        tbl[11] = '{0, 0, 8'h00, 1, 0, 1, 8'h34, 0, 8'd1, 0};
        tbl[12] = '{0, 1, 8'h00, 0, 0, 0, 8'h34, 0, 8'd0, 1};
        tbl[13] = '{0, 0, 8'h00, 0, 0, 0, 8'h34, 0, 8'd0, 1};
        tbl[14] = '{0, 0, 8'h00, 0, 0, 1, 8'h12, 0, 8'd0, 0};
        tbl[15] = '{0, 1, 8'h00, 0, 1, 0, 8'h12, 0, 8'd0, 0};
        tbl[16] = '{0, 0, 8'h00, 0, 0, 0, 8'h12, 0, 8'd0, 0};
        tbl[17] = '{1, 1, 8'h77, 1, 1, 0, 8'h12, 1, 8'd0, 1};
        tbl[18] = '{0, 0, 8'h00, 1, 0, 0, 8'h12, 0, 8'd0, 0};
        tbl[19] = '{0, 1, 8'h00, 0, 0, 0, 8'h12, 0, 8'd0, 1};
        tbl[20] = '{1, 0, 8'h99, 0, 1, 0, 8'h12, 0, 8'd0, 1};
        tbl[21] = '{0, 0, 8'h00, 0, 0, 1, 8'h77, 0, 8'd0, 0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_dv", int'(dout_valid), 0);
        chk("rst_err", int'(err), 0);
        clr = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            push = tbl[i].pu; pop = tbl[i].po; din = tbl[i].d;
            @(posedge clk); #1;
            push = 0; pop = 0;
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].er));
            chk($sformatf("v%0d_dv", i), int'(dout_valid), int'(tbl[i].dv));
            chk($sformatf("v%0d_dout", i), int'(dout), int'(tbl[i].dq));
            chk($sformatf("v%0d_we", i), int'(ram_we), int'(tbl[i].we));
            chk($sformatf("v%0d_addr", i), int'(ram_addr), int'(tbl[i].ad));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bz));
        end

        // fill to capacity, overflow attempt, then one pop
        do_clr();
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 8'(i));
            step(0, 0, 8'h00);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 256);
        step(1, 0, 8'hAB);
        chk("ovf_err", int'(err), 1);
        chk("ovf_count", int'(count), 256);
        step(0, 0, 8'h00);
        chk("ovf_err_width", int'(err), 0);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("fill_pop_dout", int'(dout), 8'hFF);
        chk("fill_pop_dv", int'(dout_valid), 1);
        chk("fill_pop_full", int'(full), 0);

        // simultaneous push/pop with one entry, then push during RD
        do_clr();
        step(1, 0, 8'h11);
        step(0, 0, 8'h00);
        step(1, 1, 8'h22);
        chk("pp_err", int'(err), 1);
        chk("pp_count", int'(count), 2);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        step(1, 0, 8'h33);
        chk("rd_push_err", int'(err), 1);
        step(0, 0, 8'h00);
        chk("rd_push_dout", int'(dout), 8'h22);
        chk("rd_push_count", int'(count), 1);

        // clear during the write cycle aborts it
        step(1, 0, 8'hAA);
        chk("wr_we_before_clr", int'(ram_we), 1);
        do_clr();
        step(1, 0, 8'h5A);
        chk("post_clr_addr", int'(ram_addr), 0);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("post_clr_dout", int'(dout), 8'h5A);

        // random traffic against the model
        do_clr();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_clr();
            end else begin
                step(bit'($urandom_range(0, 99) < 55),
                     bit'($urandom_range(0, 99) < 40),
                     8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
